// File: rtl/mux_n_rr.sv
// N-channel registered mux with valid/ready handshakes, fixed or round-robin channel choice.
// Optional registered even-parity output enabled by defining MUX_N_RR_PARITY_EN.
module mux_n_rr #(
  parameter int unsigned W  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N*W-1:0]  i_in_data,
  input  logic [N-1:0]    i_in_valid,
  output logic [N-1:0]    o_in_ready,
  input  logic            i_mode,
  input  logic [SW-1:0]   i_select,
  output logic [W-1:0]    o_out_data,
  output logic [SW-1:0]   o_out_chan,
  output logic            o_out_valid,
  input  logic            i_out_ready
`ifdef MUX_N_RR_PARITY_EN
  ,
  output logic            o_out_par
`endif
);

  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_chan;
  logic [W-1:0]  r_data;
  logic          r_valid;

  logic          w_space;
  logic          w_gnt_vld;
  logic          w_xfer;
  logic [SW-1:0] w_gnt;
  logic [W-1:0]  w_gnt_data;

  assign w_space = !r_valid || i_out_ready;
  assign w_xfer  = w_space && w_gnt_vld;

  always_comb begin
    int unsigned v_idx;
    w_gnt_vld  = 1'b0;
    w_gnt      = '0;
    w_gnt_data = '0;
    v_idx      = 0;
    if (!i_mode) begin
      // Only in-range channels are compared, so an out-of-range select never grants.
      for (int unsigned c = 0; c < N; c++) begin
        if (i_select == SW'(c) && i_in_valid[c]) begin
          w_gnt_vld  = 1'b1;
          w_gnt      = SW'(c);
          w_gnt_data = i_in_data[c*W +: W];
        end
      end
    end else begin
      // Scan ptr+1 .. ptr (mod N); first requester wins, ptr itself is checked last.
      for (int unsigned k = 1; k <= N; k++) begin
        v_idx = (32'(r_ptr) + k) % N;
        for (int unsigned c = 0; c < N; c++) begin
          if (!w_gnt_vld && v_idx == c && i_in_valid[c]) begin
            w_gnt_vld  = 1'b1;
            w_gnt      = SW'(c);
            w_gnt_data = i_in_data[c*W +: W];
          end
        end
      end
    end
  end

  always_comb begin
    o_in_ready = '0;
    for (int unsigned c = 0; c < N; c++) begin
      o_in_ready[c] = w_xfer && (w_gnt == SW'(c));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= SW'(N - 1);
    end else begin
      if (w_xfer) begin
        r_data  <= w_gnt_data;
        r_chan  <= w_gnt;
        r_valid <= 1'b1;
        if (i_mode) begin
          r_ptr <= w_gnt;
        end
      end else if (i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_N_RR_PARITY_EN
  logic r_par;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par <= 1'b0;
    end else if (w_xfer) begin
      r_par <= ^w_gnt_data;
    end
  end

  assign o_out_par = r_par;
`endif

  assign o_out_data  = r_data;
  assign o_out_chan  = r_chan;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed, table-driven bench for mux_n_rr (N=4 instance plus an N=3 instance).
module tb_mux_n_rr;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_N_RR_PARITY_EN
  logic        out_par;
  logic        t3_par;
`endif

  logic        t3_rst;
  logic [11:0] t3_data;
  logic [2:0]  t3_valid;
  logic [2:0]  t3_ready;
  logic        t3_mode;
  logic [1:0]  t3_sel;
  logic [3:0]  t3_odata;
  logic [1:0]  t3_ochan;
  logic        t3_ovalid;
  logic        t3_ordy;

  int checks;
  int failures;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [3:0] exp_d;
    logic [1:0] exp_c;
    logic       exp_p;
  } vec_t;

  vec_t vecs[$];

  mux_n_rr #(.W(4), .N(4), .SW(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_mode      (mode),
    .i_select    (sel),
    .o_out_data  (out_data),
    .o_out_chan  (out_chan),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
`ifdef MUX_N_RR_PARITY_EN
    ,
    .o_out_par   (out_par)
`endif
  );

  mux_n_rr #(.W(4), .N(3), .SW(2)) dut3 (
    .i_clk       (clk),
    .i_rst       (t3_rst),
    .i_in_data   (t3_data),
    .i_in_valid  (t3_valid),
    .o_in_ready  (t3_ready),
    .i_mode      (t3_mode),
    .i_select    (t3_sel),
    .o_out_data  (t3_odata),
    .o_out_chan  (t3_ochan),
    .o_out_valid (t3_ovalid),
    .i_out_ready (t3_ordy)
`ifdef MUX_N_RR_PARITY_EN
    ,
    .o_out_par   (t3_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    mode      = v.mode;
    sel       = v.sel;
    in_valid  = v.vld;
    out_ready = v.ordy;
    #1;
    chk("in_ready", i, 32'(in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk("out_valid", i, 32'(out_valid), 32'(v.exp_v));
    chk("out_data", i, 32'(out_data), 32'(v.exp_d));
    chk("out_chan", i, 32'(out_chan), 32'(v.exp_c));
`ifdef MUX_N_RR_PARITY_EN
    chk("out_par", i, 32'(out_par), 32'(v.exp_p));
`endif
  endtask

  task automatic t3_step(input logic m, input logic [1:0] s, input logic [2:0] e_rdy,
                         input logic e_v, input logic [3:0] e_d, input logic [1:0] e_c,
                         input int i);
    t3_mode = m;
    t3_sel  = s;
    #1;
    chk("n3_in_ready", i, 32'(t3_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk("n3_out_valid", i, 32'(t3_ovalid), 32'(e_v));
    chk("n3_out_data", i, 32'(t3_odata), 32'(e_d));
    chk("n3_out_chan", i, 32'(t3_ochan), 32'(e_c));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    in_data   = 16'hF731;
    in_valid  = 4'h0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b0;
    rst       = 1'b1;
    t3_rst    = 1'b1;
    t3_data   = 12'h731;
    t3_valid  = 3'b000;
    t3_mode   = 1'b0;
    t3_sel    = 2'd0;
    t3_ordy   = 1'b1;

    // mode sel vld ordy | in_ready valid data chan par
    vecs.push_back(vec_t'{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 4'hF, 2'd3, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 4'hF, 2'd3, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 4'hF, 2'd3, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2, 1'b1});
    // Round-robin: fixed-mode transfers left ptr at N-1, so channel 0 goes first.
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 4'hF, 2'd3, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b1});
    // Valid 1010 with a 3-cycle stall after the first word.
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 4'hF, 2'd3, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b0});
    // Single requester equal to ptr still wins.
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd1, 1'b0});
    // Empty output register accepts even with out_ready low, then stalls.
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'h4, 1'b0, 4'b0100, 1'b1, 4'h7, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b1, 2'd0, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_out_data", 0, 32'(out_data), 32'd0);
    chk("rst_out_chan", 0, 32'(out_chan), 32'd0);
`ifdef MUX_N_RR_PARITY_EN
    chk("rst_out_par", 0, 32'(out_par), 32'd0);
`endif
    rst    = 1'b0;
    t3_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Reset with a transfer in flight drops the word and restores ptr to N-1.
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("midrst_out_data", 0, 32'(out_data), 32'd0);
    chk("midrst_out_chan", 0, 32'(out_chan), 32'd0);
`ifdef MUX_N_RR_PARITY_EN
    chk("midrst_out_par", 0, 32'(out_par), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 0, 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("midrst_next_chan", 0, 32'(out_chan), 32'd0);
    chk("midrst_next_data", 0, 32'(out_data), 32'h1);
    in_valid = 4'h0;

    // N=3 instance: select 3 is out of range, then RR wraps 2 -> 0, then reset.
    t3_valid = 3'b111;
    t3_step(1'b0, 2'd3, 3'b000, 1'b0, 4'h0, 2'd0, 0);
    t3_step(1'b0, 2'd3, 3'b000, 1'b0, 4'h0, 2'd0, 1);
    t3_step(1'b1, 2'd3, 3'b001, 1'b1, 4'h1, 2'd0, 2);
    t3_step(1'b1, 2'd3, 3'b010, 1'b1, 4'h3, 2'd1, 3);
    t3_step(1'b1, 2'd3, 3'b100, 1'b1, 4'h7, 2'd2, 4);
    t3_step(1'b1, 2'd3, 3'b001, 1'b1, 4'h1, 2'd0, 5);
    t3_step(1'b1, 2'd3, 3'b010, 1'b1, 4'h3, 2'd1, 6);
    t3_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("n3_rst_out_valid", 0, 32'(t3_ovalid), 32'd0);
    chk("n3_rst_out_data", 0, 32'(t3_odata), 32'd0);
    t3_rst = 1'b0;
    t3_step(1'b1, 2'd0, 3'b001, 1'b1, 4'h1, 2'd0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects either a fixed channel (from `select`) or a round-robin arbitrated channel, and registers the chosen word with its channel index. It is the successor of the team's 4:1 combinational mux and sits between multiple producers and one consumer in the datapath experiments.

## Interface
Parameters:
- `W`, 4: data width per channel.
- `N`, 4: channel count, 2..16.
- `SW`, 2: select/channel-index width; must satisfy 2^SW >= N.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input N*W: channel c occupies bits [c*W +: W].
- `in_valid` input N: per-channel valid.
- `in_ready` output N: per-channel ready, combinational.
- `mode` input 1: 0 selects fixed mode, 1 selects round-robin mode.
- `select` input SW: channel used in fixed mode.
- `out_data` output W: registered data.
- `out_chan` output SW: registered index of the source channel.
- `out_valid` output 1: registered valid.
- `out_ready` input 1: consumer ready.
- `out_par` output 1: present only with `MUX_N_RR_PARITY_EN`; see Configuration.

## Operation
- `space` = !out_valid || out_ready. This is the output register free-or-draining condition.
- `grant`, combinational:
  - Fixed mode (`mode`=0): grant = `select` if `select` < N and in_valid[select]. Otherwise there is no grant. An out-of-range `select` never grants and never raises any in_ready.
  - Round-robin mode (`mode`=1): grant = the first c with in_valid[c], scanning ptr+1, ptr+2, … and wrapping modulo N. The scan ends at ptr itself, so ptr has the lowest priority.
- in_ready[c] = space && grant valid && grant == c. At most one in_ready bit is high in any cycle.
- A transfer occurs on channel c when in_valid[c] && in_ready[c]. On the next clk:
  - out_data <= in_data[c].
  - out_chan <= c.
  - out_valid <= 1.
- If out_valid && out_ready and there is no transfer in the same cycle, out_valid <= 0. out_data and out_chan keep their values.
- Round-robin pointer `ptr` (SW bits):
  - Updates to c only on a transfer made in round-robin mode.
  - Is unchanged by transfers made in fixed mode.
- Stall rule: while out_valid && !out_ready, out_data, out_chan and out_valid hold stable, and all in_ready are 0.

## Timing
- Reset (synchronous, `rst`=1 at a clk edge):
  - out_data=0, out_chan=0, out_valid=0.
  - ptr=N-1, so channel 0 has highest priority first.
  - out_par=0 when the feature is enabled.
- `rst` asserted mid-transfer: the reset wins and the in-flight word is dropped. in_ready remains combinational from the post-reset state.
- Latency: one cycle from a transfer to out_valid.
- Throughput: one word per cycle. A simultaneous out_ready and new transfer reloads the register with no bubble.
- `mode` and `select` are sampled combinationally each cycle. A change takes effect on grant in the same cycle, never mid-transfer of a registered word.
- Wrap-around: with ptr=N-1, the scan starts at 0.
- A single requesting channel is granted every cycle, regardless of ptr.
- N not a power of two: indices N..2^SW-1 are never granted and never written to ptr.

## Configuration
- `MUX_N_RR_PARITY_EN` defined:
  - Port `out_par` exists and is registered alongside out_data.
  - out_par = XOR-reduce of the transferred word, giving even parity over data plus par.
  - out_par holds during stalls and resets to 0.
- Not defined: the `out_par` port and its register are absent. All other behaviour is identical.

## Test plan
Configuration: N=4, W=4, in0=0001, in1=0011, in2=0111, in3=1111.
1. Fixed mode, out_ready=1, all valid, select stepped 00→01→10→11, one per cycle -> out_data 0001, 0011, 0111, 1111, each one cycle after its select, with out_chan matching and out_valid continuous.
2. Round-robin mode, all valid, out_ready=1 after reset -> out_chan sequence 0,1,2,3,0,…, with out_data following the channel values and no bubbles.
3. Round-robin, in_valid=1010, out_ready held 0 for 3 cycles after the first word -> out_data=0011 stable for 3 cycles and in_ready=0000. After release, the next out_chan is 3 (1111), then 1.
4. Fixed mode, select=10, in_valid[2]=0 -> in_ready=0000 and out_valid falls to 0 after the pending word drains. Raising in_valid[2] -> out_data=0111 one cycle later.
5. N=3 build, fixed mode, select=11, all valid -> no transfer and out_valid stays 0. `rst` asserted while out_valid=1 -> at the next edge out_data=0, out_valid=0, and the following round-robin grant is channel 0.
6. With `MUX_N_RR_PARITY_EN`, round-robin over all four channels -> out_par sequence 1,0,1,0.
